// File: rtl/afe_ro_wrr_arbiter.sv
// Round-robin arbiter multiplexing AFE write and buffer-read streams onto one SRAM port,
// with a 2-entry L2 return queue. Define AFE_RO_ARB_WEIGHT_EN to enable per-source weights.
module afe_ro_wrr_arbiter #(
  parameter int NUM_AFE     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int BUFF_AWIDTH = 10,
  parameter int L2_AWIDTH   = 12,
  parameter int WEIGHT_W    = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_AFE-1:0]               wr_valid_i,
  output logic [NUM_AFE-1:0]               wr_ready_o,
  input  logic [NUM_AFE*DATA_WIDTH-1:0]    wr_data_i,
  input  logic [NUM_AFE*BUFF_AWIDTH-1:0]   wr_addr_i,
  input  logic [NUM_AFE-1:0]               rd_valid_i,
  output logic [NUM_AFE-1:0]               rd_ready_o,
  input  logic [NUM_AFE*BUFF_AWIDTH-1:0]   rd_addr_i,
  input  logic [NUM_AFE*L2_AWIDTH-1:0]     l2_addr_i,
  input  logic [NUM_AFE*2-1:0]             l2_size_i,
  input  logic [NUM_AFE*WEIGHT_W-1:0]      weight_i,
  output logic                             buff_cen_o,
  output logic                             buff_rwn_o,
  output logic [BUFF_AWIDTH-1:0]           buff_addr_o,
  output logic [DATA_WIDTH-1:0]            buff_wdata_o,
  input  logic [DATA_WIDTH-1:0]            buff_rdata_i,
  output logic [NUM_AFE-1:0]               buff_rvalid_o,
  output logic                             intf_valid_o,
  input  logic                             intf_ready_i,
  output logic [DATA_WIDTH-1:0]            intf_wdata_o,
  output logic [L2_AWIDTH-1:0]             intf_addr_o,
  output logic [1:0]                       intf_size_o
);

  localparam int PTR_W = (NUM_AFE > 1) ? $clog2(NUM_AFE) : 1;
  localparam int TAG_W = L2_AWIDTH + 2;
  localparam int QW    = DATA_WIDTH + TAG_W;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_AFE - 1);

  logic [DATA_WIDTH-1:0]  w_wr_data [NUM_AFE];
  logic [BUFF_AWIDTH-1:0] w_wr_addr [NUM_AFE];
  logic [BUFF_AWIDTH-1:0] w_rd_addr [NUM_AFE];
  logic [TAG_W-1:0]       w_rd_tag  [NUM_AFE];
  logic [WEIGHT_W-1:0]    w_weight  [NUM_AFE];

  for (genvar gi = 0; gi < NUM_AFE; gi++) begin : g_unpack
    assign w_wr_data[gi] = wr_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_wr_addr[gi] = wr_addr_i[gi*BUFF_AWIDTH +: BUFF_AWIDTH];
    assign w_rd_addr[gi] = rd_addr_i[gi*BUFF_AWIDTH +: BUFF_AWIDTH];
    assign w_rd_tag[gi]  = {l2_addr_i[gi*L2_AWIDTH +: L2_AWIDTH], l2_size_i[gi*2 +: 2]};
    assign w_weight[gi]  = weight_i[gi*WEIGHT_W +: WEIGHT_W];
  end

  // First requester after ptr in circular order; returns ptr itself if only it requests.
  function automatic logic [PTR_W-1:0] rr_next(input logic [NUM_AFE-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] idx_p;
    pick = ptr;
    for (int k = NUM_AFE; k >= 1; k--) begin
      idx_p = PTR_W'((int'(ptr) + k) % NUM_AFE);
      if (req[idx_p]) pick = idx_p;
    end
    return pick;
  endfunction

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             w_wr_keep;
  logic             w_rd_keep;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_rd_idx;
  logic             w_wr_gnt;
  logic             w_rd_gnt;
  logic             w_rd_credit;
  logic [2:0]       w_occ;
  logic             w_pop;
  logic             w_push;

  logic             r_inflight;
  logic [PTR_W-1:0] r_inf_src;
  logic [TAG_W-1:0] r_inf_tag;

  logic [QW-1:0]    r_q_mem [2];
  logic             r_q_head;
  logic             r_q_tail;
  logic [1:0]       r_q_cnt;
  logic [QW-1:0]    w_q_head;

  logic [BUFF_AWIDTH-1:0] r_addr_last;
  logic [DATA_WIDTH-1:0]  r_wdata_last;

`ifdef AFE_RO_ARB_WEIGHT_EN
  logic [WEIGHT_W-1:0] r_wcnt;
  logic [WEIGHT_W-1:0] r_wbud;
  logic [WEIGHT_W-1:0] r_rcnt;
  logic [WEIGHT_W-1:0] r_rbud;

  assign w_wr_keep = wr_valid_i[r_wptr] && (r_wcnt < r_wbud);
  assign w_rd_keep = rd_valid_i[r_rptr] && (r_rcnt < r_rbud);

  // Counters track grants already given to the current owner; the budget reloads on owner change.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wcnt <= '0;
      r_wbud <= '0;
      r_rcnt <= '0;
      r_rbud <= '0;
    end else begin
      if (w_wr_gnt) begin
        if (w_wr_keep) begin
          r_wcnt <= r_wcnt + 1'b1;
        end else begin
          r_wcnt <= '0;
          r_wbud <= w_weight[w_wr_idx];
        end
      end
      if (w_rd_gnt) begin
        if (w_rd_keep) begin
          r_rcnt <= r_rcnt + 1'b1;
        end else begin
          r_rcnt <= '0;
          r_rbud <= w_weight[w_rd_idx];
        end
      end
    end
  end
`else
  logic w_unused_weight;
  assign w_unused_weight = ^weight_i;
  assign w_wr_keep = 1'b0;
  assign w_rd_keep = 1'b0;
`endif

  assign w_wr_idx = w_wr_keep ? r_wptr : rr_next(wr_valid_i, r_wptr);
  assign w_rd_idx = w_rd_keep ? r_rptr : rr_next(rd_valid_i, r_rptr);

  assign w_pop       = (r_q_cnt != 2'd0) && intf_ready_i;
  assign w_push      = r_inflight;
  assign w_occ       = {2'b00, r_inflight} + {1'b0, r_q_cnt} - {2'b00, w_pop};
  assign w_rd_credit = (w_occ < 3'd2);

  assign w_wr_gnt = rst_ni && (|wr_valid_i);
  assign w_rd_gnt = rst_ni && (|rd_valid_i) && !w_wr_gnt && w_rd_credit;

  always_comb begin
    wr_ready_o   = '0;
    rd_ready_o   = '0;
    buff_cen_o   = 1'b1;
    buff_rwn_o   = 1'b1;
    buff_addr_o  = r_addr_last;
    buff_wdata_o = r_wdata_last;
    if (w_wr_gnt) begin
      wr_ready_o[w_wr_idx] = 1'b1;
      buff_cen_o           = 1'b0;
      buff_rwn_o           = 1'b0;
      buff_addr_o          = w_wr_addr[w_wr_idx];
      buff_wdata_o         = w_wr_data[w_wr_idx];
    end else if (w_rd_gnt) begin
      rd_ready_o[w_rd_idx] = 1'b1;
      buff_cen_o           = 1'b0;
      buff_addr_o          = w_rd_addr[w_rd_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr       <= LAST_IDX;
      r_rptr       <= LAST_IDX;
      r_inflight   <= 1'b0;
      r_inf_src    <= '0;
      r_inf_tag    <= '0;
      r_addr_last  <= '0;
      r_wdata_last <= '0;
    end else begin
      if (w_wr_gnt) r_wptr <= w_wr_idx;
      if (w_rd_gnt) r_rptr <= w_rd_idx;
      r_inflight   <= w_rd_gnt;
      r_inf_src    <= w_rd_idx;
      r_inf_tag    <= w_rd_tag[w_rd_idx];
      r_addr_last  <= buff_addr_o;
      r_wdata_last <= buff_wdata_o;
    end
  end

  always_comb begin
    buff_rvalid_o = '0;
    if (r_inflight && rst_ni) buff_rvalid_o[r_inf_src] = 1'b1;
  end

  // Credit check guarantees a push never lands on a full queue.
  always_ff @(posedge clk_i) begin
    if (w_push) r_q_mem[r_q_tail] <= {buff_rdata_i, r_inf_tag};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_q_head <= 1'b0;
      r_q_tail <= 1'b0;
      r_q_cnt  <= 2'd0;
    end else begin
      if (w_push) r_q_tail <= ~r_q_tail;
      if (w_pop)  r_q_head <= ~r_q_head;
      case ({w_push, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + 2'd1;
        2'b01:   r_q_cnt <= r_q_cnt - 2'd1;
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

  assign w_q_head     = r_q_mem[r_q_head];
  assign intf_valid_o = (r_q_cnt != 2'd0);
  assign intf_wdata_o = w_q_head[QW-1 -: DATA_WIDTH];
  assign intf_addr_o  = w_q_head[TAG_W-1:2];
  assign intf_size_o  = w_q_head[1:0];

endmodule

// File: tb/tb_afe_ro_wrr_arbiter.sv
// Self-checking bench for afe_ro_wrr_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model. Honours AFE_RO_ARB_WEIGHT_EN like the design.
module tb_afe_ro_wrr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 12;
  localparam int WW = 4;
`ifdef AFE_RO_ARB_WEIGHT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    wr_valid, wr_ready, rd_valid, rd_ready, rvalid;
  logic [N*DW-1:0] wr_data;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*LW-1:0] l2_addr;
  logic [N*2-1:0]  l2_size;
  logic [N*WW-1:0] weight;
  logic            cen, rwn;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata, rdata;
  logic            intf_valid, intf_ready;
  logic [DW-1:0]   intf_wdata;
  logic [LW-1:0]   intf_addr;
  logic [1:0]      intf_size;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sram [1024];

  afe_ro_wrr_arbiter #(.NUM_AFE(N), .DATA_WIDTH(DW), .BUFF_AWIDTH(AW),
                       .L2_AWIDTH(LW), .WEIGHT_W(WW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data), .wr_addr_i(wr_addr),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
    .l2_addr_i(l2_addr), .l2_size_i(l2_size), .weight_i(weight),
    .buff_cen_o(cen), .buff_rwn_o(rwn), .buff_addr_o(addr), .buff_wdata_o(wdata),
    .buff_rdata_i(rdata), .buff_rvalid_o(rvalid),
    .intf_valid_o(intf_valid), .intf_ready_i(intf_ready), .intf_wdata_o(intf_wdata),
    .intf_addr_o(intf_addr), .intf_size_o(intf_size)
  );

  always #5 clk = ~clk;

  // Single-port SRAM: read data one cycle after the access; initial content is word i at address i.
  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = DW'(i);
    forever begin
      @(posedge clk);
      if (!cen) begin
        if (rwn) rdata <= sram[addr];
        else     sram[addr] = wdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_valid = '1; rd_valid = '1;
    @(negedge clk);
    checks++; if (wr_ready !== 4'b0) begin errors++; $display("FAIL reset_wr_ready got=%b exp=0000", wr_ready); end
    checks++; if (rd_ready !== 4'b0) begin errors++; $display("FAIL reset_rd_ready got=%b exp=0000", rd_ready); end
    checks++; if (cen !== 1'b1) begin errors++; $display("FAIL reset_cen got=%b exp=1", cen); end
    cyc; wr_valid = '0; rd_valid = '0;
    cyc; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (intf_valid !== 1'b0) begin errors++; $display("FAIL reset_intf_valid got=%b exp=0", intf_valid); end
    checks++; if (rvalid !== 4'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
    cyc;
  endtask

  task automatic test_wr_round_robin;
    int e;
    for (int i = 0; i < N; i++) begin
      wr_addr[i*AW +: AW] = AW'(10'h100 + i);
      wr_data[i*DW +: DW] = 32'hA000_0000 + DW'(i);
    end
    wr_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      e = c % N;
      checks++;
      if (wr_ready !== N'(1 << e) || {cen, rwn} !== 2'b00 || addr !== AW'(10'h100 + e)) begin
        errors++;
        $display("FAIL wr_rr cycle %0d got ready=%b cen/rwn=%b addr=%h exp ready=%b cen/rwn=00 addr=%h",
                 c, wr_ready, {cen, rwn}, addr, N'(1 << e), AW'(10'h100 + e));
      end
      cyc;
    end
    wr_valid = '0;
  endtask

  task automatic test_read_latency;
    rd_addr[2*AW +: AW] = 10'h005;
    l2_addr[2*LW +: LW] = 12'hABC;
    l2_size[2*2 +: 2]   = 2'd2;
    rd_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (rd_ready !== 4'b0100 || {cen, rwn} !== 2'b01 || addr !== 10'h005) begin
      errors++;
      $display("FAIL rd_grant got ready=%b cen/rwn=%b addr=%h exp ready=0100 cen/rwn=01 addr=005",
               rd_ready, {cen, rwn}, addr);
    end
    cyc; rd_valid = '0;
    @(negedge clk);
    checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL rd_rvalid got=%b exp=0100", rvalid); end
    checks++; if (intf_valid !== 1'b0) begin errors++; $display("FAIL rd_early_valid got=%b exp=0", intf_valid); end
    cyc;
    @(negedge clk);
    checks++;
    if (intf_valid !== 1'b1 || intf_wdata !== 32'h5 || intf_addr !== 12'hABC || intf_size !== 2'd2) begin
      errors++;
      $display("FAIL rd_word got valid=%b data=%h addr=%h size=%0d exp valid=1 data=00000005 addr=abc size=2",
               intf_valid, intf_wdata, intf_addr, intf_size);
    end
    cyc;
    @(negedge clk);
    checks++; if (intf_valid !== 1'b0) begin errors++; $display("FAIL rd_drained got=%b exp=0", intf_valid); end
    cyc;
  endtask

  task automatic test_write_beats_read;
    wr_valid = 4'b0010;
    rd_valid = 4'b0001;
    rd_addr[0 +: AW] = 10'h007;
    l2_addr[0 +: LW] = 12'h111;
    @(negedge clk);
    checks++;
    if (wr_ready !== 4'b0010 || rd_ready !== 4'b0000 || rwn !== 1'b0) begin
      errors++;
      $display("FAIL wr_beats_rd got wr=%b rd=%b rwn=%b exp wr=0010 rd=0000 rwn=0", wr_ready, rd_ready, rwn);
    end
    cyc; wr_valid = '0;
    @(negedge clk);
    checks++;
    if (rd_ready !== 4'b0001 || {cen, rwn} !== 2'b01 || addr !== 10'h007) begin
      errors++;
      $display("FAIL rd_after_wr got rd=%b cen/rwn=%b addr=%h exp rd=0001 cen/rwn=01 addr=007",
               rd_ready, {cen, rwn}, addr);
    end
    cyc; rd_valid = '0;
    cyc;
    @(negedge clk);
    checks++;
    if (intf_valid !== 1'b1 || intf_wdata !== 32'h7 || intf_addr !== 12'h111) begin
      errors++;
      $display("FAIL rd_after_wr_word got valid=%b data=%h addr=%h exp valid=1 data=00000007 addr=111",
               intf_valid, intf_wdata, intf_addr);
    end
    repeat (3) cyc;
  endtask

  task automatic test_backpressure;
    int src_q[$];
    int grants;
    intf_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd_addr[i*AW +: AW] = AW'(10'h010 + i);
      l2_addr[i*LW +: LW] = LW'(12'h200 + i);
      l2_size[i*2 +: 2]   = 2'(i);
    end
    rd_valid = 4'hF;
    grants = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (rd_ready[i]) begin grants++; src_q.push_back(i); end
      cyc;
    end
    @(negedge clk);
    checks++; if (grants != 2) begin errors++; $display("FAIL bp_grant_count got=%0d exp=2", grants); end
    checks++; if (rd_ready !== 4'b0) begin errors++; $display("FAIL bp_stalled got=%b exp=0000", rd_ready); end
    checks++; if (intf_valid !== 1'b1) begin errors++; $display("FAIL bp_queue_full_valid got=%b exp=1", intf_valid); end
    cyc; intf_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (src_q.size() == 0) begin
        errors++;
        $display("FAIL bp_stream cycle %0d got no pending grant exp one pending word", c);
      end else if (intf_valid !== 1'b1 || intf_wdata !== DW'(16 + src_q[0]) ||
                   intf_addr !== LW'(12'h200 + src_q[0])) begin
        errors++;
        $display("FAIL bp_stream cycle %0d got valid=%b data=%h addr=%h exp valid=1 data=%h addr=%h",
                 c, intf_valid, intf_wdata, intf_addr, DW'(16 + src_q[0]), LW'(12'h200 + src_q[0]));
      end
      if (src_q.size() != 0) void'(src_q.pop_front());
      for (int i = 0; i < N; i++) if (rd_ready[i]) src_q.push_back(i);
      cyc;
    end
    rd_valid = '0;
    repeat (4) cyc;
  endtask

  task automatic test_weights;
    int exp_seq[8];
    rst_n = 1'b0; cyc; rst_n = 1'b1;
    weight = '0;
    weight[0 +: WW] = 4'd2;
    wr_valid = 4'b0011;
    for (int c = 0; c < 8; c++) exp_seq[c] = WEN ? ((c % 4 == 3) ? 1 : 0) : (c % 2);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (wr_ready !== N'(1 << exp_seq[c])) begin
        errors++;
        $display("FAIL weights cycle %0d got=%b exp=%b", c, wr_ready, N'(1 << exp_seq[c]));
      end
      cyc;
    end
    wr_valid = '0;
    weight = '0;
  endtask

  task automatic test_reset_inflight;
    intf_ready = 1'b0;
    rd_addr[0 +: AW] = 10'h020;
    rd_valid = 4'b0001;
    @(negedge clk);
    checks++; if (rd_ready !== 4'b0001) begin errors++; $display("FAIL ri_first got=%b exp=0001", rd_ready); end
    cyc;
    @(negedge clk);
    checks++; if (rd_ready !== 4'b0001) begin errors++; $display("FAIL ri_second got=%b exp=0001", rd_ready); end
    cyc; rd_valid = '0; rst_n = 1'b0;
    @(negedge clk);
    checks++; if (intf_valid !== 1'b1) begin errors++; $display("FAIL ri_queued got=%b exp=1", intf_valid); end
    checks++; if (rvalid !== 4'b0) begin errors++; $display("FAIL ri_rvalid_in_reset got=%b exp=0000", rvalid); end
    cyc; rst_n = 1'b1; rd_valid = 4'hF;
    @(negedge clk);
    checks++; if (intf_valid !== 1'b0) begin errors++; $display("FAIL ri_valid_after got=%b exp=0", intf_valid); end
    checks++; if (rvalid !== 4'b0) begin errors++; $display("FAIL ri_rvalid_after got=%b exp=0000", rvalid); end
    checks++; if (rd_ready !== 4'b0001) begin errors++; $display("FAIL ri_src0_wins got=%b exp=0001", rd_ready); end
    cyc; rd_valid = '0; intf_ready = 1'b1;
    repeat (3) cyc;
  endtask

  typedef struct packed {
    logic [DW-1:0] d;
    logic [LW-1:0] a;
    logic [1:0]    s;
  } word_t;

  function automatic int rr_first(logic [N-1:0] req, int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic test_random;
    logic [DW-1:0] m_mem [16];
    word_t q[$];
    word_t pend;
    bit    pend_v;
    int    pend_src;
    int    wlast, rlast, wcnt, wbud, rcnt, rbud;
    int    widx, ridx, occ;
    bit    pop;
    logic [N-1:0] exp_rv;
    for (int i = 0; i < 16; i++) m_mem[i] = DW'(i);
    wlast = N - 1; rlast = N - 1; wcnt = 0; wbud = 0; rcnt = 0; rbud = 0;
    pend_v = 1'b0; pend_src = 0; pend = '0;
    rst_n = 1'b0; wr_valid = '0; rd_valid = '0; cyc; rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        wr_valid[i] = ($urandom_range(0, 3) == 0);
        rd_valid[i] = ($urandom_range(0, 1) == 1);
        wr_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
        rd_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
        wr_data[i*DW +: DW] = DW'($urandom);
        l2_addr[i*LW +: LW] = LW'($urandom);
        l2_size[i*2 +: 2]   = 2'($urandom_range(0, 3));
        weight[i*WW +: WW]  = WW'($urandom_range(0, 3));
      end
      intf_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);

      exp_rv = pend_v ? N'(1 << pend_src) : '0;
      checks++;
      if (rvalid !== exp_rv) begin errors++; $display("FAIL rnd_rvalid cycle %0d got=%b exp=%b", c, rvalid, exp_rv); end

      checks++;
      if (q.size() != 0) begin
        if (intf_valid !== 1'b1 || {intf_wdata, intf_addr, intf_size} !== q[0]) begin
          errors++;
          $display("FAIL rnd_head cycle %0d got valid=%b word=%h exp valid=1 word=%h",
                   c, intf_valid, {intf_wdata, intf_addr, intf_size}, q[0]);
        end
      end else if (intf_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd_head cycle %0d got valid=%b exp valid=0", c, intf_valid);
      end
      pop = (q.size() != 0) && intf_ready;
      if (pop) $display("tb: L2 word data=%h addr=%h size=%0d", q[0].d, q[0].a, q[0].s);

      occ  = int'(pend_v) + q.size() - int'(pop);
      ridx = -1;
      widx = -1;
      if (wr_valid != '0) begin
        if (WEN && wr_valid[wlast] && wcnt < wbud) begin
          widx = wlast; wcnt++;
        end else begin
          widx = rr_first(wr_valid, wlast); wcnt = 0; wbud = int'(weight[widx*WW +: WW]);
        end
        wlast = widx;
        checks++;
        if (wr_ready !== N'(1 << widx) || rd_ready !== '0 || {cen, rwn} !== 2'b00 ||
            addr !== wr_addr[widx*AW +: AW] || wdata !== wr_data[widx*DW +: DW]) begin
          errors++;
          $display("FAIL rnd_write cycle %0d got wr=%b rd=%b cen/rwn=%b addr=%h data=%h exp wr=%b rd=0000 cen/rwn=00 addr=%h data=%h",
                   c, wr_ready, rd_ready, {cen, rwn}, addr, wdata, N'(1 << widx),
                   wr_addr[widx*AW +: AW], wr_data[widx*DW +: DW]);
        end
      end else if (rd_valid != '0 && occ < 2) begin
        if (WEN && rd_valid[rlast] && rcnt < rbud) begin
          ridx = rlast; rcnt++;
        end else begin
          ridx = rr_first(rd_valid, rlast); rcnt = 0; rbud = int'(weight[ridx*WW +: WW]);
        end
        rlast = ridx;
        checks++;
        if (rd_ready !== N'(1 << ridx) || wr_ready !== '0 || {cen, rwn} !== 2'b01 ||
            addr !== rd_addr[ridx*AW +: AW]) begin
          errors++;
          $display("FAIL rnd_read cycle %0d got rd=%b wr=%b cen/rwn=%b addr=%h exp rd=%b wr=0000 cen/rwn=01 addr=%h",
                   c, rd_ready, wr_ready, {cen, rwn}, addr, N'(1 << ridx), rd_addr[ridx*AW +: AW]);
        end
      end else begin
        checks++;
        if (wr_ready !== '0 || rd_ready !== '0 || cen !== 1'b1) begin
          errors++;
          $display("FAIL rnd_idle cycle %0d got wr=%b rd=%b cen=%b exp wr=0000 rd=0000 cen=1",
                   c, wr_ready, rd_ready, cen);
        end
      end

      if (pop) void'(q.pop_front());
      if (pend_v) q.push_back(pend);
      pend_v = (ridx >= 0);
      if (ridx >= 0) begin
        pend_src = ridx;
        pend.d   = m_mem[rd_addr[ridx*AW +: 4]];
        pend.a   = l2_addr[ridx*LW +: LW];
        pend.s   = l2_size[ridx*2 +: 2];
      end
      if (widx >= 0) m_mem[wr_addr[widx*AW +: 4]] = wr_data[widx*DW +: DW];
      cyc;
    end
    wr_valid = '0; rd_valid = '0; intf_ready = 1'b1;
    repeat (4) cyc;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = '0; rd_valid = '0; wr_data = '0; wr_addr = '0; rd_addr = '0;
    l2_addr = '0; l2_size = '0; weight = '0; intf_ready = 1'b1;
    test_reset();
    test_wr_round_robin();
    test_read_latency();
    test_write_beats_read();
    test_backpressure();
    test_weights();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afe_ro_wrr_arbiter.md
# afe_ro_wrr_arbiter

Parametrised next-generation readout arbiter between the per-receiver AFE tops and the shared single-port sample buffer and uDMA interface adapter. It multiplexes any number of AFE write streams and buffer-read streams onto one SRAM port. Arbitration is round-robin with optional per-source weights. Read data returns through a 2-entry output queue that decouples SRAM latency from uDMA back-pressure and sustains one L2 word per cycle.

## Interface
- NUM_AFE, 4, number of AFE sources (≥1)
- DATA_WIDTH, 32, sample/L2 word width
- BUFF_AWIDTH, 10, buffer address width
- L2_AWIDTH, 12, L2 address width (non-aligned)
- WEIGHT_W, 4, width of per-source weight

Clock and reset: one clock; reset is synchronous and active-low.

- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- wr_valid_i  in  NUM_AFE  source requests a buffer write
- wr_ready_o  out  NUM_AFE  write grant, one-hot or zero
- wr_data_i  in  NUM_AFE×DATA_WIDTH  write data
- wr_addr_i  in  NUM_AFE×BUFF_AWIDTH  write address
- rd_valid_i  in  NUM_AFE  source requests a buffer read toward L2
- rd_ready_o  out  NUM_AFE  read grant, one-hot or zero
- rd_addr_i  in  NUM_AFE×BUFF_AWIDTH  read address
- l2_addr_i  in  NUM_AFE×L2_AWIDTH  L2 destination of the read word
- l2_size_i  in  NUM_AFE×2  L2 transfer size
- weight_i  in  NUM_AFE×WEIGHT_W  consecutive-grant budget minus 1
- buff_cen_o  out  1  SRAM chip enable, active-low
- buff_rwn_o  out  1  SRAM 1 = read, 0 = write
- buff_addr_o  out  BUFF_AWIDTH  SRAM address
- buff_wdata_o  out  DATA_WIDTH  SRAM write data
- buff_rdata_i  in  DATA_WIDTH  SRAM read data, one cycle after the read
- buff_rvalid_o  out  NUM_AFE  one-hot pulse to the source whose read data returns
- intf_valid_o  out  1  L2 word valid toward the uDMA adapter
- intf_ready_i  in  1  uDMA adapter accepts
- intf_wdata_o  out  DATA_WIDTH  L2 word
- intf_addr_o  out  L2_AWIDTH  L2 address
- intf_size_o  out  2  L2 size

## Operation
- At most one SRAM access per cycle. Writes always beat reads; AFE input has no back-pressure slack.
- Write and read arbitration use separate round-robin pointers (wptr, rptr) that hold the last granted index. The search starts at ptr+1 mod NUM_AFE, and the first requester wins.
- Read grant additionally requires a credit: inflight + q_cnt − pop < 2. Here inflight is a read issued last cycle, q_cnt is the queue occupancy (0..2), and pop = intf_valid_o & intf_ready_i.
- The write grant drives buff_cen_o=0, buff_rwn_o=0, and the address/data of the winner.
- The read grant drives buff_cen_o=0, buff_rwn_o=1, and rd_addr_i of the winner. The winner's l2_addr_i and l2_size_i are captured into the inflight tag.
- With no grant: buff_cen_o=1, buff_rwn_o=1, and address/data hold their previous mux value (don't-care).
- Cycle t+1 after a read: buff_rvalid_o[src]=1. The word {buff_rdata_i, tag} is pushed into the queue tail.
- The queue head drives the intf_* outputs. intf_valid_o = (q_cnt≠0). Head data stays stable until the handshake.
- Push and pop in the same cycle keep q_cnt unchanged. Queue pointers wrap mod 2.
- A pointer advances only on a grant, to the granted index.

## Timing
- Grants and SRAM controls are combinational in the request cycle. Read data reaches intf_valid_o no earlier than cycle t+2.
- Sustained throughput is 1 read/cycle with intf_ready_i=1 and no write traffic.
- Reset (rst_ni=0 at a clock edge) sets wptr=rptr=NUM_AFE−1 (source 0 wins first), q_cnt=0, inflight=0, and weight counters to 0.
- While rst_ni=0: all grants are 0 and buff_cen_o=1.
- After reset: intf_valid_o=0 and buff_rvalid_o=0. A read in flight at reset is discarded and its buff_rvalid_o is not pulsed.
- NUM_AFE=1: the pointer is constant 0 and arbitration degenerates to a priority check.

## Configuration
- AFE_RO_ARB_WEIGHT_EN defined:
  - The current owner keeps the grant for up to weight_i[owner]+1 consecutive grants while it keeps requesting. A per-class counter counts the grants.
  - The pointer moves past the owner when the budget is exhausted or the owner drops its request. The counter then reloads for the new owner.
  - Weights are sampled at each owner change.
- Undefined: weight_i is ignored; every grant advances the pointer (plain round-robin).

## Test plan
- Reset, then wr_valid_i=4'b1111 held for 8 cycles, weights 0 → wr_ready_o sequence 0,1,2,3,0,1,2,3.
- rd_valid_i[2]=1 with rd_addr 0x05, intf_ready_i=1 → buff_rvalid_o[2] at t+1; intf_valid_o at t+2 with SRAM word 0x05 and l2_addr_i[2].
- Write and read requested in the same cycle → write granted; read granted in the next cycle; no SRAM conflict.
- intf_ready_i=0, continuous reads → exactly 2 reads granted, q_cnt=2, rd_ready_o=0. Release ready → 1 word/cycle with data order preserved.
- Macro defined, weight_i[0]=2, both sources 0 and 1 writing → grant pattern 0,0,0,1,0,0,0,1. Undefined → 0,1,0,1.
- Reset asserted while a read is in flight and q_cnt=1 → next cycle intf_valid_o=0, buff_rvalid_o=0, and source 0 wins the next grant.
